firefly_method_arbiter: RTL and testbench

- Round-robin arbiter that shares one c2ir-generated method port among N requesters. The method port is a req/busy pair with two 32-bit arguments, e.g. firefly_led_req/_busy/_a/_b.
- Each client posts a request with its own arguments. The arbiter grants one client at a time, drives the method handshake and reports completion or timeout back to the granted client.
- Sits between control logic (test sequencers, host-register decoders) and the firefly_led instance.

---
 rtl/firefly_method_arbiter.sv | 152 +++++++++++++++
 tb/tb_firefly_method_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/firefly_method_arbiter.sv
// Round-robin arbiter sharing one req/busy method port (two 32-bit args) among N clients.
// One transaction in flight at a time; completion or ack timeout is pulsed back to the winner.
module firefly_method_arbiter #(
    parameter int N           = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int IDX_W       = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      cli_req,
    input  logic [32*N-1:0]   cli_a,
    input  logic [32*N-1:0]   cli_b,
    output logic [N-1:0]      cli_done,
    output logic [N-1:0]      cli_err,
    output logic              grant_valid,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              m_req,
    output logic [31:0]       m_a,
    output logic [31:0]       m_b,
    input  logic              m_busy
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT);
    localparam int SUM_W = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic               gvalid_q, gvalid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mreq_q, mreq_d;
    logic [31:0]        ma_q, ma_d, mb_q, mb_d;
    logic [N-1:0]       done_q, done_d, err_q, err_d;

    logic [2*N-1:0]     req_dbl;
    logic [IDX_W-1:0]   win_off, win_idx, rr_next;
    logic [SUM_W-1:0]   win_sum;
    logic [31:0]        a_sel, b_sel;
    logic [N-1:0]       gnt_oh;

    // Rotate requests so bit 0 is the rr pointer; the lowest set bit is the winner's offset.
    always_comb begin
        req_dbl = {cli_req, cli_req} >> rr_q;
        win_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_dbl[k]) win_off = IDX_W'(k);
        end
        win_sum = {1'b0, rr_q} + {1'b0, win_off};
        win_idx = (win_sum >= SUM_W'(N)) ? IDX_W'(win_sum - SUM_W'(N)) : IDX_W'(win_sum);
        rr_next = (win_idx == IDX_W'(N - 1)) ? '0 : win_idx + IDX_W'(1);
    end

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        gnt_oh = '0;
        for (int k = 0; k < N; k++) begin
            if (win_idx == IDX_W'(k)) begin
                a_sel = cli_a[32*k +: 32];
                b_sel = cli_b[32*k +: 32];
            end
            gnt_oh[k] = (gidx_q == IDX_W'(k));
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gidx_d   = gidx_q;
        gvalid_d = gvalid_q;
        cnt_d    = cnt_q;
        mreq_d   = mreq_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        done_d   = '0;
        err_d    = '0;
        case (state_q)
            S_IDLE: begin
                // A busy callee in IDLE belongs to another master; hold off granting.
                if ((|cli_req) && !m_busy) begin
                    state_d  = S_ISSUE;
                    gidx_d   = win_idx;
                    gvalid_d = 1'b1;
                    mreq_d   = 1'b1;
                    ma_d     = a_sel;
                    mb_d     = b_sel;
                    rr_d     = rr_next;
                    cnt_d    = '0;
                end
            end
            S_ISSUE: begin
                if (m_busy) begin
                    mreq_d  = 1'b0;
                    state_d = S_RUN;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    mreq_d   = 1'b0;
                    gvalid_d = 1'b0;
                    err_d    = gnt_oh;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!m_busy) begin
                    done_d   = gnt_oh;
                    gvalid_d = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            gidx_q   <= '0;
            gvalid_q <= 1'b0;
            cnt_q    <= '0;
            mreq_q   <= 1'b0;
            ma_q     <= '0;
            mb_q     <= '0;
            done_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gidx_q   <= gidx_d;
            gvalid_q <= gvalid_d;
            cnt_q    <= cnt_d;
            mreq_q   <= mreq_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cli_done    = done_q;
    assign cli_err     = err_q;
    assign grant_valid = gvalid_q;
    assign grant_idx   = gidx_q;
    assign m_req       = mreq_q;
    assign m_a         = ma_q;
    assign m_b         = mb_q;

endmodule

// File: tb/tb_firefly_method_arbiter.sv
// Directed bench for firefly_method_arbiter: a small callee model drives m_busy and a
// scoreboard of expected (client, args, done/err) records is checked on every completion.
module tb_firefly_method_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    cli_req;
    logic [32*N-1:0] cli_a, cli_b;
    logic [N-1:0]    cli_done, cli_err;
    logic            grant_valid;
    logic [IW-1:0]   grant_idx;
    logic            m_req;
    logic [31:0]     m_a, m_b;
    logic            m_busy;

    int checks = 0;
    int errors = 0;
    int done_cnt [N];

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        bit          err;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    firefly_method_arbiter #(.N(N), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cli_req(cli_req), .cli_a(cli_a), .cli_b(cli_b),
        .cli_done(cli_done), .cli_err(cli_err), .grant_valid(grant_valid),
        .grant_idx(grant_idx), .m_req(m_req), .m_a(m_a), .m_b(m_b), .m_busy(m_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_arg(input int i, input logic [31:0] a, input logic [31:0] b);
        cli_a[32*i +: 32] = a;
        cli_b[32*i +: 32] = b;
    endtask

    task automatic push(input int idx, input logic [31:0] a, input logic [31:0] b, input bit err);
        exp_t e;
        e.idx = idx; e.a = a; e.b = b; e.err = err;
        sbq.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_done"}, cli_done, 0);
        chk({tag, "_err"}, cli_err, 0);
        chk({tag, "_gvalid"}, grant_valid, 0);
        chk({tag, "_gidx"}, grant_idx, 0);
        chk({tag, "_mreq"}, m_req, 0);
        chk({tag, "_ma"}, m_a, 0);
        chk({tag, "_mb"}, m_b, 0);
    endtask

    // Callee model: cycle 0 is the first cycle m_req is seen; busy is high in [dly, dly+len).
    task automatic run_txn(input int dly, input int len, input bit ack, input bit drop,
                           input int chg_cyc, input logic [31:0] chg_val,
                           output int wait_n);
        int cyc, mreq_n, gidx, idx, exp_cyc;
        bit got;
        logic [31:0] a0, b0;
        exp_t e;
        wait_n = 0; mreq_n = 0; got = 1'b0; idx = -1;
        while (!m_req && wait_n < 60) begin
            tick();
            wait_n++;
        end
        chk("mreq_seen", m_req, 1);
        if (!m_req) return;
        chk("gvalid_issue", grant_valid, 1);
        gidx = int'(grant_idx);
        a0 = m_a; b0 = m_b;
        exp_cyc = ack ? dly + len + 1 : TO;
        for (cyc = 0; cyc < 200 && !got; cyc++) begin
            if (|(cli_done | cli_err)) begin
                got = 1'b1;
                for (int i = 0; i < N; i++) if (cli_done[i] | cli_err[i]) idx = i;
                chk("onehot", $countones(cli_done | cli_err), 1);
                chk("done_cycle", cyc, exp_cyc);
                chk("mreq_cycles", mreq_n, ack ? dly + 1 : TO);
                chk("gvalid_end", grant_valid, 0);
                chk("sb_nonempty", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("done_idx", idx, e.idx);
                    chk("grant_idx", gidx, e.idx);
                    chk("is_err", cli_err != 0, e.err);
                    chk("m_a_grant", a0, e.a);
                    chk("m_b_grant", b0, e.b);
                    chk("m_a_end", m_a, e.a);
                    chk("m_b_end", m_b, e.b);
                end
                if (cli_done != 0 && idx >= 0) done_cnt[idx]++;
                if (drop && idx >= 0) cli_req[idx] = 1'b0;
            end else begin
                if (m_req) mreq_n++;
                if (cyc == chg_cyc) cli_a[32*gidx +: 32] = chg_val;
                m_busy = ack && (cyc >= dly) && (cyc < dly + len);
                tick();
            end
        end
        chk("txn_complete", got, 1);
        m_busy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset = 1'b1; cli_req = '0; cli_a = '0; cli_b = '0; m_busy = 1'b0;
        foreach (done_cnt[i]) done_cnt[i] = 0;
        tick(); tick();
        check_idle_outputs("rst");
        reset = 1'b0;
        tick();

        // Single call to client 1
        set_arg(1, 32'h11, 32'h22);
        cli_req = 4'b0010;
        push(1, 32'h11, 32'h22, 1'b0);
        chk("mreq_before", m_req, 0);
        tick();
        chk("mreq_next_cycle", m_req, 1);
        run_txn(1, 5, 1'b1, 1'b1, -1, 32'h0, w);
        chk("single_wait", w, 0);
        tick();
        chk("done_one_cycle", cli_done, 0);

        // Round robin from a fresh pointer, requests held throughout
        reset = 1'b1; tick(); reset = 1'b0;
        foreach (done_cnt[i]) done_cnt[i] = 0;
        for (int i = 0; i < N; i++) set_arg(i, 32'hA0 + i, 32'hB0 + i);
        cli_req = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            push(t % N, 32'hA0 + (t % N), 32'hB0 + (t % N), 1'b0);
            run_txn(1, 3, 1'b1, 1'b0, -1, 32'h0, w);
            if (t > 0) chk("rr_gap", w, 2);
        end
        cli_req = '0;
        for (int i = 0; i < N; i++) chk("rr_count", done_cnt[i], 2);
        tick(); tick();

        // Ack timeout, then a normal call to the same client
        set_arg(2, 32'h33, 32'h44);
        cli_req = 4'b0100;
        push(2, 32'h33, 32'h44, 1'b1);
        run_txn(1, 1, 1'b0, 1'b1, -1, 32'h0, w);
        tick();
        chk("to_gvalid", grant_valid, 0);
        chk("to_mreq", m_req, 0);
        chk("to_err_pulse", cli_err, 0);
        cli_req = 4'b0100;
        push(2, 32'h33, 32'h44, 1'b0);
        run_txn(1, 2, 1'b1, 1'b1, -1, 32'h0, w);
        tick();

        // Callee held by someone else while idle
        set_arg(0, 32'h55, 32'h66);
        m_busy = 1'b1;
        cli_req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ext_busy_no_mreq", m_req, 0);
        end
        m_busy = 1'b0;
        tick();
        chk("ext_busy_release", m_req, 1);
        push(0, 32'h55, 32'h66, 1'b0);
        run_txn(1, 2, 1'b1, 1'b1, -1, 32'h0, w);
        tick();

        // Async reset during RUN of client 2 (rr would otherwise point at 3)
        set_arg(2, 32'h77, 32'h88);
        cli_req = 4'b0100;
        w = 0;
        while (!m_req && w < 20) begin tick(); w++; end
        m_busy = 1'b1;
        tick(); tick();
        chk("pre_rst_run", {m_req, grant_valid}, 2'b01);
        #2 reset = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        m_busy = 1'b0;
        set_arg(1, 32'h1111, 32'h2222);
        set_arg(3, 32'h3333, 32'h4444);
        cli_req = 4'b1010;
        tick();
        reset = 1'b0;
        push(1, 32'h1111, 32'h2222, 1'b0);
        push(3, 32'h3333, 32'h4444, 1'b0);
        run_txn(1, 2, 1'b1, 1'b1, -1, 32'h0, w);
        run_txn(1, 2, 1'b1, 1'b1, -1, 32'h0, w);
        tick();

        // Argument change during RUN must not leak into the current call
        set_arg(0, 32'h100, 32'h101);
        cli_req = 4'b0001;
        push(0, 32'h100, 32'h101, 1'b0);
        run_txn(1, 5, 1'b1, 1'b1, 3, 32'h200, w);
        tick();
        cli_req = 4'b0001;
        push(0, 32'h200, 32'h101, 1'b0);
        run_txn(1, 2, 1'b1, 1'b1, -1, 32'h0, w);
        tick();

        chk("sb_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
